// File: rtl/serial_paralelo_pkg.sv
// Shared types and constants for the serial-to-parallel byte aligner.
package serial_paralelo_pkg;

    // Default idle/comma character used for byte alignment.
    localparam logic [7:0] BC_BYTE_DEF = 8'hBC;

    // Bit position counter within a byte (8 bits per byte).
    localparam int unsigned BIT_CNT_W = 3;

    // Consecutive-comma counter; wide enough for the 1..15 lock requirement.
    localparam int unsigned BC_CNT_W = 4;

    // Last bit position of a byte; the byte boundary falls on this count.
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = 3'd7;

    typedef enum logic [1:0] {
        StSearch = 2'd0,
        StAlign  = 2'd1,
        StActive = 2'd2
    } state_e;

    // Increment a comma count, saturating at the lock requirement.
    function automatic logic [BC_CNT_W-1:0] bc_cnt_inc(
        input logic [BC_CNT_W-1:0] cnt,
        input logic [BC_CNT_W-1:0] req
    );
        if (cnt >= req) begin
            return req;
        end
        return cnt + 4'd1;
    endfunction

endpackage

// File: rtl/serial_paralelo_sync_comma_detect.sv
// Serial shift register plus comma compare on the live 8-bit window.
// The window includes the bit currently on data_i so a comma is seen on the
// same edge that samples its last bit.
module sp_comma_detect
    import serial_paralelo_pkg::*;
#(
    parameter logic [7:0] BC_BYTE = BC_BYTE_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       data_i,
    output logic [7:0] window_o,
    output logic       is_bc_o
);

    logic [7:0] sr_q;
    logic [7:0] sr_d;

    // Window and shift-register next state share the same value.
    always_comb begin
        sr_d     = {sr_q[6:0], data_i};
        window_o = sr_d;
        is_bc_o  = (sr_d == BC_BYTE);
    end

    // Shift one bit per clock, MSB first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q <= 8'h00;
        end else begin
            sr_q <= sr_d;
        end
    end

endmodule

// File: rtl/serial_paralelo_sync.sv
// Deserialises an MSB-first bit stream into bytes, aligns on the comma
// character and reports lock after BC_REQ consecutive aligned commas.
module serial_paralelo_sync
    import serial_paralelo_pkg::*;
#(
    parameter logic [7:0]  BC_BYTE = BC_BYTE_DEF,
    parameter int unsigned BC_REQ  = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active
);

    localparam logic [BC_CNT_W-1:0] BcReq = BC_REQ[BC_CNT_W-1:0];

    logic [7:0] window;
    logic       is_bc;

    state_e                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [BC_CNT_W-1:0]    bc_cnt_q, bc_cnt_d;
    logic [7:0]             data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   active_q, active_d;

    sp_comma_detect #(
        .BC_BYTE (BC_BYTE)
    ) u_comma_detect (
        .clk_i    (clk_32f),
        .rst_i    (reset),
        .data_i   (data_in),
        .window_o (window),
        .is_bc_o  (is_bc)
    );

    // Alignment FSM, counters and output next-state.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bc_cnt_d  = bc_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        active_d  = active_q;

        case (state_q)
            StSearch: begin
                // Any bit position may start a comma; this edge defines the boundary.
                if (is_bc) begin
                    bit_cnt_d = '0;
                    bc_cnt_d  = 4'd1;
                    if (BcReq == 4'd1) begin
                        state_d  = StActive;
                        active_d = 1'b1;
                    end else begin
                        state_d = StAlign;
                    end
                end
            end

            StAlign: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == BIT_LAST) begin
                    if (is_bc) begin
                        bc_cnt_d = bc_cnt_inc(bc_cnt_q, BcReq);
                        if (bc_cnt_d == BcReq) begin
                            state_d  = StActive;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Boundary guess was wrong; resume bit-by-bit search.
                        state_d   = StSearch;
                        bc_cnt_d  = '0;
                        bit_cnt_d = '0;
                    end
                end
            end

            StActive: begin
                // Locked for good: only reset leaves this state.
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == BIT_LAST) begin
                    data_d  = window;
                    valid_d = !is_bc;
                end
            end

            default: begin
                state_d = StSearch;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q   <= StSearch;
            bit_cnt_q <= '0;
            bc_cnt_q  <= '0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bc_cnt_q  <= bc_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign active    = active_q;

endmodule

// File: tb/tb_serial_paralelo_sync.sv
// Directed bench for serial_paralelo_sync: byte-level vector table plus
// hand-written sequences for junk-bit offset and mid-stream reset.
module tb_serial_paralelo_sync;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       exp_active;
    } vec_t;

    localparam int NVEC = 24;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b1;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t vecs [NVEC];

    // Expected outputs currently held (from the last completed byte).
    logic [7:0] hold_data;
    logic       hold_valid;
    logic       hold_active;

    serial_paralelo_sync #(
        .BC_BYTE (8'hBC),
        .BC_REQ  (4)
    ) dut (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string name, input logic [7:0] d, input logic v,
                         input logic a);
        n_cmp++;
        if (data_out !== d || valid_out !== v || active !== a) begin
            n_bad++;
            $display("FAIL %s @%0t: got data=%h valid=%b active=%b, want data=%h valid=%b active=%b",
                     name, $time, data_out, valid_out, active, d, v, a);
        end
    endtask

    // Drive one bit and sample 1 time unit after the edge that takes it.
    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    // Send one byte MSB first; every non-final bit must see held outputs.
    task automatic send_vec(input vec_t v, input string name);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v.din[i]);
            if (i != 0) begin
                check({name, "_hold"}, hold_data, hold_valid, hold_active);
            end else begin
                check(name, v.exp_data, v.exp_valid, v.exp_active);
            end
        end
        hold_data   = v.exp_data;
        hold_valid  = v.exp_valid;
        hold_active = v.exp_active;
    endtask

    task automatic run_vecs(input int lo, input int hi, input string name);
        for (int k = lo; k <= hi; k++) begin
            send_vec(vecs[k], $sformatf("%s[%0d]", name, k));
        end
    endtask

    task automatic do_reset(input int cycles);
        reset   = 1'b1;
        data_in = 1'b1;
        repeat (cycles) begin
            @(posedge clk_32f);
            #1;
        end
        check("reset", 8'h00, 1'b0, 1'b0);
        reset       = 1'b0;
        hold_data   = 8'h00;
        hold_valid  = 1'b0;
        hold_active = 1'b0;
    endtask

    initial begin
        // Lock after offset, then payload and idle while active.
        vecs[0]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{8'hBC, 8'h00, 1'b0, 1'b1};
        vecs[4]  = '{8'h5A, 8'h5A, 1'b1, 1'b1};
        vecs[5]  = '{8'hBC, 8'hBC, 1'b0, 1'b1};
        vecs[6]  = '{8'hFF, 8'hFF, 1'b1, 1'b1};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 1'b1};
        // Broken comma run.
        vecs[8]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{8'hBC, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{8'h11, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        vecs[12] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        vecs[13] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        vecs[14] = '{8'hBC, 8'h00, 1'b0, 1'b1};
        vecs[15] = '{8'h3C, 8'h3C, 1'b1, 1'b1};
        // False comma straddling a nibble offset, then idle zeros.
        vecs[16] = '{8'h0B, 8'h00, 1'b0, 1'b0};
        vecs[17] = '{8'hC0, 8'h00, 1'b0, 1'b0};
        vecs[18] = '{8'h00, 8'h00, 1'b0, 1'b0};
        vecs[19] = '{8'h00, 8'h00, 1'b0, 1'b0};
        // Relock before the mid-stream reset test.
        vecs[20] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        vecs[21] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        vecs[22] = '{8'hBC, 8'h00, 1'b0, 1'b0};
        vecs[23] = '{8'hBC, 8'h00, 1'b0, 1'b1};

        // Reset held 3 cycles with data_in high.
        do_reset(3);

        // Three junk bits put the first comma at a non-zero bit offset.
        send_bit(1'b1);
        check("junk0", 8'h00, 1'b0, 1'b0);
        send_bit(1'b0);
        check("junk1", 8'h00, 1'b0, 1'b0);
        send_bit(1'b1);
        check("junk2", 8'h00, 1'b0, 1'b0);
        run_vecs(0, 7, "lock");

        do_reset(1);
        run_vecs(8, 15, "broken");

        do_reset(1);
        run_vecs(16, 19, "false_bc");

        do_reset(1);
        run_vecs(20, 23, "relock");
        send_vec('{8'h55, 8'h55, 1'b1, 1'b1}, "s55");

        // Reset for one cycle in the middle of the next 0x55.
        send_bit(1'b0);
        check("mid55_hold0", 8'h55, 1'b1, 1'b1);
        send_bit(1'b1);
        check("mid55_hold1", 8'h55, 1'b1, 1'b1);
        reset = 1'b1;
        send_bit(1'b0);
        check("mid_reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;

        // A pure 0x55 stream contains no comma and must never relock.
        for (int n = 0; n < 48; n++) begin
            send_bit(n[0] ? 1'b0 : 1'b1);
            check("no_relock", 8'h00, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion, want completion before 200000");
        $fatal(1);
    end

endmodule
